// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and slave state type shared by ahb_master and ahb_slave_mem
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Little-endian lane enables for a legal (byte/half/word) access.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    byte_en = 4'b0001 << lane;
            2'd1:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// rtl/ahb_slave_ram.sv - single-port word RAM with byte-write enables and asynchronous read
module ahb_slave_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite SRAM slave with wait states and two-cycle ERROR response
// Optional transfer statistics outputs: AHB_SLV_STATS_EN
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
`ifdef AHB_SLV_STATS_EN
    ,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_err
`endif
);

    localparam int          AW     = $clog2(MEM_DEPTH);
    localparam logic [3:0]  WS     = 4'(WAIT_STATES);
    localparam logic [32:0] BASE33 = {1'b0, ADDR_BASE};
    localparam logic [32:0] SPAN   = 33'(MEM_DEPTH) << 2;

    slv_state_e    state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;

    logic          accept;
    logic          take;
    logic          last_cyc;
    logic          chk_fail;
    logic          misaligned;
    logic          in_range;
    logic [32:0]   offset;
    logic [3:0]    ram_be;
    logic [31:0]   ram_rdata;
    logic          unused_sig;

    assign accept = HSEL & HREADY & HTRANS[1];

    // 33-bit compare so a window touching 4 GiB cannot wrap into a false hit.
    assign offset     = {1'b0, HADDR} - BASE33;
    assign in_range   = ({1'b0, HADDR} >= BASE33) && (offset < SPAN);
    assign misaligned = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                        ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign chk_fail   = (HSIZE > HSIZE_WORD) || misaligned || !in_range;

    assign last_cyc = (state_q == ST_DATA) && (wcnt_q == WS);
    assign take     = (state_q == ST_IDLE) || (state_q == ST_ERR2) || last_cyc;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        size_d    = size_q;
        write_d   = write_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_IDLE: ;
            ST_DATA: begin
                if (!last_cyc) begin
                    HREADYOUT = 1'b0;
                    wcnt_d    = wcnt_q + 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = HRESP_ERROR;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (take && accept) begin
            state_d = chk_fail ? ST_ERR1 : ST_DATA;
            wcnt_d  = 4'd0;
            idx_d   = offset[AW+1:2];
            lane_d  = HADDR[1:0];
            size_d  = HSIZE[1:0];
            write_d = HWRITE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    assign ram_be = (last_cyc && write_q && !HRESET) ? byte_en(size_q, lane_q) : 4'b0000;
    assign HRDATA = ((state_q == ST_DATA) && !write_q) ? ram_rdata : 32'h0;

    ahb_slave_ram #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (HCLK),
        .addr_i  (idx_q),
        .be_i    (ram_be),
        .wdata_i (HWDATA),
        .rdata_o (ram_rdata)
    );

`ifdef AHB_SLV_STATS_EN
    logic [15:0] stat_wr_q, stat_rd_q, stat_err_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            stat_wr_q  <= 16'h0;
            stat_rd_q  <= 16'h0;
            stat_err_q <= 16'h0;
        end else begin
            if (last_cyc && write_q && (stat_wr_q != 16'hFFFF)) begin
                stat_wr_q <= stat_wr_q + 16'd1;
            end
            if (last_cyc && !write_q && (stat_rd_q != 16'hFFFF)) begin
                stat_rd_q <= stat_rd_q + 16'd1;
            end
            if (take && accept && chk_fail && (stat_err_q != 16'hFFFF)) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end

    assign stat_wr  = stat_wr_q;
    assign stat_rd  = stat_rd_q;
    assign stat_err = stat_err_q;
`endif

    assign unused_sig = ^{HBURST, HTRANS[0], offset[32:AW+2], offset[1:0]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - scoreboard bench for ahb_slave_mem (zero-wait and two-wait instances)
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  trans;
        logic [2:0]  burst;
    } beat_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic [2:0]  hburst = HBURST_SINGLE;
    logic [2:0]  hsize = HSIZE_WORD;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = 32'h0;
    int          sel = 0;
    logic        sel0, sel1;
    logic        ro0, ro1, rp0, rp1;
    logic [31:0] rd0, rd1;

    int n_chk = 0;
    int n_err = 0;
    beat_t beats[$];
    exp_t  sb[$];
    logic [31:0] mdl0 [256];
    logic [31:0] mdl1 [256];
    int ewr[2], erd[2], eerr[2];

    always #5 hclk = ~hclk;

    assign sel0 = hsel && (sel == 0);
    assign sel1 = hsel && (sel == 1);

`ifdef AHB_SLV_STATS_EN
    logic [15:0] sw0, sr0, se0, sw1, sr1, se1;
`endif

    ahb_slave_mem #(.ADDR_BASE(32'h0000_0000), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HBURST(hburst), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ro0),
        .HREADYOUT(ro0), .HRESP(rp0), .HRDATA(rd0)
`ifdef AHB_SLV_STATS_EN
        , .stat_wr(sw0), .stat_rd(sr0), .stat_err(se0)
`endif
    );

    ahb_slave_mem #(.ADDR_BASE(32'h0000_1000), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut1 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans),
        .HBURST(hburst), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ro1),
        .HREADYOUT(ro1), .HRESP(rp1), .HRDATA(rd1)
`ifdef AHB_SLV_STATS_EN
        , .stat_wr(sw1), .stat_rd(sr1), .stat_err(se1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_err(input int inst, input logic [31:0] a, input logic [2:0] s);
        logic [32:0] base, lim;
        base = (inst == 1) ? 33'h1000 : 33'h0;
        lim  = base + 33'd1024;
        if (s > 3'd2) return 1'b1;
        if ((s == 3'd1) && a[0]) return 1'b1;
        if ((s == 3'd2) && (a[1:0] != 2'b00)) return 1'b1;
        if (({1'b0, a} < base) || ({1'b0, a} >= lim)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int widx(input int inst, input logic [31:0] a);
        logic [31:0] off;
        off = a - ((inst == 1) ? 32'h1000 : 32'h0);
        return int'(off[9:2]);
    endfunction

    task automatic mdl_write(input int inst, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] d);
        logic [31:0] w;
        int start, nb;
        w     = (inst == 1) ? mdl1[widx(inst, a)] : mdl0[widx(inst, a)];
        start = int'(a[1:0]);
        nb    = 1 << s;
        for (int b = 0; b < 4; b++) begin
            if (b >= start && b < start + nb) w[8*b +: 8] = d[8*b +: 8];
        end
        if (inst == 1) mdl1[widx(inst, a)] = w;
        else           mdl0[widx(inst, a)] = w;
    endtask

    task automatic add(input logic [31:0] a, input logic [2:0] s, input logic wr,
                       input logic [31:0] d, input logic [1:0] tr, input logic [2:0] bu);
        beat_t b;
        b.addr = a; b.size = s; b.wr = wr; b.wdata = d; b.trans = tr; b.burst = bu;
        beats.push_back(b);
    endtask

    task automatic push_expected(input int inst, input beat_t b);
        exp_t e;
        bit err;
        err     = mdl_err(inst, b.addr, b.size);
        e.resp  = err;
        e.waits = err ? 1 : ((inst == 1) ? 2 : 0);
        e.rdata = 32'h0;
        if (err) begin
            eerr[inst]++;
        end else if (b.wr) begin
            mdl_write(inst, b.addr, b.size, b.wdata);
            ewr[inst]++;
        end else begin
            e.rdata = (inst == 1) ? mdl1[widx(inst, b.addr)] : mdl0[widx(inst, b.addr)];
            erd[inst]++;
        end
        sb.push_back(e);
    endtask

    task automatic run_beats(input int inst);
        int a = 0;
        bit pend = 0;
        int waits = 0;
        int cyc = 0;
        logic rsp_w = 1'b0;
        logic [31:0] pwd = 32'h0;
        logic rdy, rsp;
        logic [31:0] rdt;
        exp_t e;
        sel = inst;
        while ((a < beats.size() || pend) && cyc < 400) begin
            @(negedge hclk);
            cyc++;
            if (a < beats.size()) begin
                hsel = 1'b1; haddr = beats[a].addr; htrans = beats[a].trans;
                hsize = beats[a].size; hwrite = beats[a].wr; hburst = beats[a].burst;
            end else begin
                hsel = 1'b0; htrans = HTRANS_IDLE;
            end
            hwdata = pwd;
            rdy = (inst == 1) ? ro1 : ro0;
            rsp = (inst == 1) ? rp1 : rp0;
            rdt = (inst == 1) ? rd1 : rd0;
            if (pend) begin
                if (!rdy) begin
                    waits++;
                    rsp_w |= rsp;
                end else begin
                    e = sb.pop_front();
                    check("hresp", 32'(rsp), 32'(e.resp));
                    check("hrdata", rdt, e.rdata);
                    check("wait_cycles", waits, e.waits);
                    check("wait_resp", 32'(rsp_w), 32'(e.resp));
                    pend = 1'b0;
                end
            end
            if (rdy && a < beats.size()) begin
                if (beats[a].trans[1]) begin
                    push_expected(inst, beats[a]);
                    pend = 1'b1; pwd = beats[a].wdata; waits = 0; rsp_w = 1'b0;
                end
                a++;
            end
        end
        if (cyc >= 400) check("timeout", 32'd1, 32'd0);
        beats.delete();
        sb.delete();
        @(negedge hclk);
        hsel = 1'b0; htrans = HTRANS_IDLE;
    endtask

    task automatic do_reset();
        hreset = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE;
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        for (int i = 0; i < 2; i++) begin ewr[i] = 0; erd[i] = 0; eerr[i] = 0; end
    endtask

`ifdef AHB_SLV_STATS_EN
    task automatic check_stats();
        check("stat_wr0", 32'(sw0), ewr[0]);  check("stat_rd0", 32'(sr0), erd[0]);
        check("stat_err0", 32'(se0), eerr[0]); check("stat_wr1", 32'(sw1), ewr[1]);
        check("stat_rd1", 32'(sr1), erd[1]);  check("stat_err1", 32'(se1), eerr[1]);
    endtask
`endif

    initial begin
        do_reset();
        check("rst_ready0", 32'(ro0), 32'd1); check("rst_resp0", 32'(rp0), 32'd0);
        check("rst_rdata0", rd0, 32'd0);      check("rst_ready1", 32'(ro1), 32'd1);
        check("rst_resp1", 32'(rp1), 32'd0);  check("rst_rdata1", rd1, 32'd0);

        add(32'h10, HSIZE_WORD, 1, 32'hDEADBEEF, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h10, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        run_beats(0);

        for (int i = 0; i < 4; i++)
            add(32'h1000 + 32'(4*i), HSIZE_WORD, 1, 32'hA5A50000 + 32'(i * 32'h1111),
                (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR4);
        for (int i = 0; i < 4; i++) begin
            add(32'h1000 + 32'(4*i), HSIZE_WORD, 0, 32'h0,
                (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_WRAP4);
            if (i == 1) add(32'h1008, HSIZE_WORD, 0, 32'h0, HTRANS_BUSY, HBURST_WRAP4);
        end
        run_beats(1);

        add(32'h0, HSIZE_WORD, 1, 32'h11223344, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h4, HSIZE_WORD, 1, 32'h55667788, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h3, HSIZE_BYTE, 1, 32'hAA000000, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h0, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h2, HSIZE_HALF, 1, 32'hBEEF0000, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h0, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h6, HSIZE_WORD, 1, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h4, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h400, HSIZE_WORD, 1, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h4, 3'b011, 1, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h1, HSIZE_HALF, 1, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h4, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h0, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        run_beats(0);

        add(32'h0FFC, HSIZE_WORD, 1, 32'h12345678, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h1400, HSIZE_WORD, 1, 32'h12345678, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h13FC, HSIZE_WORD, 1, 32'h0BADF00D, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h13FC, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h1020, HSIZE_WORD, 1, 32'h01234567, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h1000, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        run_beats(1);
`ifdef AHB_SLV_STATS_EN
        check_stats();
`endif

        @(negedge hclk);
        sel = 1; hsel = 1'b1; haddr = 32'h1020; htrans = HTRANS_NONSEQ;
        hwrite = 1'b1; hsize = HSIZE_WORD; hburst = HBURST_SINGLE;
        @(negedge hclk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hCAFEF00D;
        check("rst_mid_wait1", 32'(ro1), 32'd0);
        @(negedge hclk);
        check("rst_mid_wait2", 32'(ro1), 32'd0);
        hreset = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
        for (int i = 0; i < 2; i++) begin ewr[i] = 0; erd[i] = 0; eerr[i] = 0; end
        check("rst_mid_ready", 32'(ro1), 32'd1);
        check("rst_mid_resp", 32'(rp1), 32'd0);
        check("rst_mid_rdata", rd1, 32'd0);
        add(32'h1020, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        run_beats(1);

`ifdef AHB_SLV_STATS_EN
        do_reset();
        add(32'h20, HSIZE_WORD, 1, 32'h1, HTRANS_NONSEQ, HBURST_INCR);
        add(32'h24, HSIZE_WORD, 1, 32'h2, HTRANS_SEQ, HBURST_INCR);
        add(32'h28, HSIZE_BYTE, 1, 32'h3, HTRANS_SEQ, HBURST_INCR);
        add(32'h20, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h22, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        add(32'h24, HSIZE_WORD, 0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
        run_beats(0);
        check("stats_wr3", 32'(sw0), 32'd3);
        check("stats_rd2", 32'(sr0), 32'd2);
        check("stats_err1", 32'(se0), 32'd1);
        do_reset();
        check_stats();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite slave that terminates the master's bus: word-organised SRAM behind an address window, with programmable wait-state insertion and a two-cycle ERROR response. Sits directly downstream of ahb_master. In a single-slave system its HREADYOUT is fed back as the master's and its own HREADY, and HRESP/HRDATA drive the master directly. Brings up master burst, wait and error paths against a real responder.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of word 0; must be aligned to MEM_DEPTH*4.
MEM_DEPTH, 256, number of 32-bit words; power of two, 4..4096.
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase, 0..15.

Ports:
HCLK  in  1  bus clock; all logic on rising edge
HRESET  in  1  synchronous active-high reset
HSEL  in  1  slave select, qualifies address phase
HADDR  in  32  byte address
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HBURST  in  3  burst type; accepted, no effect on response
HSIZE  in  3  000 byte, 001 half, 010 word; others illegal
HWRITE  in  1  1 = write, 0 = read
HWDATA  in  32  write data, valid in data phase
HREADY  in  1  bus ready; an address phase completes when high
HREADYOUT  out  1  slave ready for current data phase
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  32  read data

Behaviour:
- Reset (sync, HRESET=1 at edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0. Memory contents are not cleared. Reset mid-transfer abandons the transfer; no write commits on a reset edge.
- Accept: address phase is taken on an edge where HSEL & HREADY & HTRANS[1]. On accept, latch addr, size and write; run checks.
- IDLE, BUSY or HSEL=0: no data phase. Zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Checks (any fail -> ERROR):
  - HSIZE>2.
  - Misaligned: half needs addr[0]=0; word needs addr[1:0]=0.
  - Address outside [ADDR_BASE, ADDR_BASE+MEM_DEPTH*4).
- States: IDLE, DATA, ERR1, ERR2.
- IDLE: on accept, go to DATA (checks pass) or ERR1 (checks fail).
- DATA:
  - HREADYOUT=0 while wait counter < WAIT_STATES; the counter increments each cycle.
  - Final cycle: HREADYOUT=1, HRESP=0.
  - On the final-cycle edge, a write commits HWDATA byte lanes selected by size and addr[1:0] (little-endian lanes). A read presents HRDATA = mem[word index] combinationally during that cycle.
  - HRDATA=0 outside read data phases.
  - On the final-cycle edge, a new accept goes to DATA/ERR1 with counter reset to 0; otherwise go to IDLE.
- ERR1: HREADYOUT=0, HRESP=1, no memory access. Next state ERR2.
- ERR2: HREADYOUT=1, HRESP=1. An accept on this edge is processed normally; otherwise go to IDLE.
- Pipelining: back-to-back transfers have no bubble. Read of a word written in the immediately preceding transfer returns the new data.
- Word index = (addr - ADDR_BASE) >> 2, width clog2(MEM_DEPTH). Address compare is done in 33-bit unsigned arithmetic, so ADDR_BASE+size overflow cannot false-match.
- HBURST is ignored: every beat is checked independently, and a wrap boundary needs no special handling.

Optional Feature:
AHB_SLV_STATS_EN
- Defined: adds outputs stat_wr, stat_rd, stat_err (16 bits each, reset 0, saturating at 16'hFFFF).
  - stat_wr/stat_rd increment on each committed OKAY write/read final cycle.
  - stat_err increments on entry to ERR1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
  - HSIZE codes.
  - HRESP OKAY/ERROR.
  - HBURST codes (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8), shared with ahb_master.
  - Slave state enum.
- One sub-module, ahb_slave_ram: single-port MEM_DEPTH x 32 array with 4-bit byte-write enable and async read. The FSM, checks and counters stay in the top.

Test Plan:
- WAIT_STATES=0, NONSEQ word write 0xDEADBEEF to ADDR_BASE+0x10, then read it -> write completes in 1 data cycle; read HRDATA=0xDEADBEEF, HRESP=0.
- WAIT_STATES=2, SEQ 4-beat word writes then reads at 0x0..0xC -> each data phase has HREADYOUT low 2 cycles then high; readback matches; no lost beats.
- Byte write 0xAA to addr 0x3 over word 0x11223344 -> read word returns 0xAA223344. Half write 0xBEEF at 0x2 -> 0xBEEF3344.
- Word access at addr 0x6 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged. Same for addr ADDR_BASE+MEM_DEPTH*4 and for HSIZE=3.
- Assert HRESET during the 2nd wait cycle of a write -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; target word unchanged.
- AHB_SLV_STATS_EN defined: 3 writes, 2 reads, 1 error -> stat_wr=3, stat_rd=2, stat_err=1; all return to 0 after reset.
